// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine between the control FSM and a
// single-port word memory. Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses fault through ERR instead of being aligned down.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memRead,
  output logic        mem_memWrite,
  input  logic [31:0] mem_memData,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  // access size code: 0 = byte, 1 = half, 2 = word; stores with funct3[2]=1
  // and every unlisted encoding fall back to a word access
  function automatic logic [1:0] acc_size(input logic w, input logic [2:0] f3);
    if (!(w && f3[2]) && f3[1:0] == 2'b00) return 2'd0;
    if (!(w && f3[2]) && f3[1:0] == 2'b01) return 2'd1;
    return 2'd2;
  endfunction

  state_t      state;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;

  logic [1:0]  size_in, size_q;
  logic        mis_in;
  logic [31:0] shifted, load_val, merged;

  assign size_in = acc_size(we, funct3);
  assign size_q  = acc_size(we_q, funct3_q);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in = (size_in == 2'd1 && addr[0]) || (size_in == 2'd2 && addr[1:0] != 2'b00);
`else
  assign mis_in = 1'b0;
`endif

  // load extraction straight from the memory bus during RD
  always_comb begin
    shifted  = mem_memData >> {addr_q[1:0], 3'b000};
    load_val = mem_memData;
    case (size_q)
      2'd0: load_val = funct3_q[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: begin
        // half select uses addr_q[1] only, so an odd address aligns down
        load_val = mem_memData >> {addr_q[1], 4'b0000};
        load_val = funct3_q[2] ? {16'b0, load_val[15:0]} : {{16{load_val[15]}}, load_val[15:0]};
      end
      default: load_val = mem_memData;
    endcase
  end

  // store merge of the captured word with the new byte/half
  always_comb begin
    merged = word_q;
    case (size_q)
      2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // control FSM with the latched request and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          addr_q   <= addr;
          wdata_q  <= wdata;
          funct3_q <= funct3;
          we_q     <= we;
          if (mis_in)                       state <= ERR;
          else if (we && size_in == 2'd2)   state <= WR;
          else                              state <= RD;
        end
        RD: begin
          word_q <= mem_memData;
          if (we_q) state <= WR;
          else begin
            rdata_q <= load_val;
            state   <= DONE;
          end
        end
        WR:        state <= DONE;
        DONE, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // strobes are gated by reset so an access aborted mid-flight never touches memory
  assign mem_address   = {addr_q[31:2], 2'b00};
  assign mem_writeData = merged;
  assign mem_memRead   = (state == RD) && !reset;
  assign mem_memWrite  = (state == WR) && !reset;
  assign busy          = (state != IDLE) && !reset;
  assign done          = (state == DONE || state == ERR) && !reset;
  assign rdata         = reset ? 32'b0 : rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned    = (state == ERR) && !reset;
`else
  assign misaligned    = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: byte-level reference memory model vs. the DUT, with
// directed scenarios followed by random accesses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] mem_address, mem_writeData, mem_memData, rdata;
  logic        mem_memRead, mem_memWrite, busy, done, misaligned;

  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  logic [7:0]  rb [256];
  logic [31:0] model_rdata;
  int          n_vec = 0, n_err = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_memData(mem_memData),
    .rdata(rdata), .busy(busy), .done(done), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // word memory: combinational read, write on the rising edge
  assign mem_memData = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_memWrite) mem[mem_address[7:2]] <= mem_writeData;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rword(input int a);
    return {rb[a+3], rb[a+2], rb[a+1], rb[a]};
  endfunction

  task automatic poke(input int byte_a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 6'(byte_a >> 2); poke_val = v;
    for (int i = 0; i < 4; i++) rb[(byte_a & ~3) + i] = 8'(v >> (8 * i));
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic access(input logic w, input logic [2:0] f3, input int ai,
                        input logic [31:0] wd, input int hold);
    int sz, lat, ea, wa, n_done, n_mis, n_rd, n_wr, first, both;
    bit trap, sgn;
    logic [31:0] val, exp_rd, exp_word;
    sz   = (!(w && f3[2]) && f3[1:0] == 2'b00) ? 1 :
           (!(w && f3[2]) && f3[1:0] == 2'b01) ? 2 : 4;
    sgn  = !f3[2];
    trap = TRAP && (ai % sz != 0);
    ea   = ai - ai % sz;
    wa   = ea - ea % 4;
    lat  = trap ? 1 : (w && sz < 4) ? 3 : 2;
    exp_rd = model_rdata;
    if (!trap && !w) begin
      val = '0;
      for (int i = 0; i < sz; i++) val = val | (32'(rb[ea+i]) << (8 * i));
      if (sgn && sz == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (sgn && sz == 2 && val[15]) val = val | 32'hFFFF_0000;
      exp_rd = val;
      model_rdata = val;
    end
    if (!trap && w) for (int i = 0; i < sz; i++) rb[ea+i] = 8'(wd >> (8 * i));
    exp_word = rword(wa);

    @(negedge clk);
    we = w; funct3 = f3; addr = 32'(ai); wdata = wd; req = 1'b1;
    @(posedge clk);
    n_done = 0; n_mis = 0; n_rd = 0; n_wr = 0; first = 0; both = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c >= hold) req = 1'b0;
      if (done) begin n_done++; if (first == 0) first = c; end
      if (misaligned) n_mis++;
      if (mem_memRead) begin n_rd++; chk("rd_addr", mem_address, 32'(wa)); end
      if (mem_memWrite) begin
        n_wr++;
        chk("wr_addr", mem_address, 32'(wa));
        chk("wr_data", mem_writeData, exp_word);
      end
      if (mem_memRead && mem_memWrite) both++;
      if (c == lat) chk("rdata_at_done", rdata, exp_rd);
    end
    chk("latency", 32'(first), 32'(lat));
    chk("done_pulses", 32'(n_done), 32'd1);
    chk("mis_pulses", 32'(n_mis), trap ? 32'd1 : 32'd0);
    chk("rd_cycles", 32'(n_rd), (trap || (w && sz == 4)) ? 32'd0 : 32'd1);
    chk("wr_cycles", 32'(n_wr), (w && !trap) ? 32'd1 : 32'd0);
    chk("rd_wr_overlap", 32'(both), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rdata_held", rdata, exp_rd);
    chk("mem_word", mem[wa >> 2], exp_word);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    model_rdata = '0;
    for (int i = 0; i < 64; i++) poke(4 * i, $urandom);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'b0, mem_memRead, mem_memWrite}, 32'd0);
    reset = 1'b0;

    // sign/zero-extended byte loads
    poke(32'h8C, 32'h0000_00F2);
    access(1'b0, 3'b000, 32'h8C, 32'h0, 1);
    chk("lb_8c", rdata, 32'hFFFF_FFF2);
    access(1'b0, 3'b100, 32'h8C, 32'h0, 1);
    chk("lbu_8c", rdata, 32'h0000_00F2);

    // byte store RMW
    poke(32'h90, 32'h1122_3344);
    access(1'b1, 3'b000, 32'h92, 32'h0000_00AB, 1);
    chk("sb_92_word", mem[32'h90 >> 2], 32'h11AB_3344);

    // word store then half loads
    access(1'b1, 3'b010, 32'h94, 32'hDEAD_BEEF, 1);
    access(1'b0, 3'b001, 32'h96, 32'h0, 1);
    chk("lh_96", rdata, 32'hFFFF_DEAD);
    access(1'b0, 3'b101, 32'h94, 32'h0, 1);
    chk("lhu_94", rdata, 32'h0000_BEEF);

    // misaligned word load
    access(1'b0, 3'b010, 32'h95, 32'h0, 1);
    chk("lw_95", rdata, TRAP ? 32'h0000_BEEF : 32'hDEAD_BEEF);

    // req held for three cycles yields a single access
    access(1'b0, 3'b010, 32'h94, 32'h0, 3);

    // reset in the WR cycle of an sb aborts the write
    poke(32'h98, 32'h5566_7788);
    @(negedge clk);
    we = 1'b1; funct3 = 3'b000; addr = 32'h99; wdata = 32'h0000_00CC; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("abort_rd", 32'(mem_memRead), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_wr_gated", 32'(mem_memWrite), 32'd0);
    chk("abort_busy_rst", 32'(busy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_mem", mem[32'h98 >> 2], 32'h5566_7788);
    chk("abort_rdata", rdata, 32'd0);

    // random traffic
    for (int k = 0; k < 250; k++)
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), $urandom, int'($urandom_range(1, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
